// File: rtl/csr_defs.sv
// Shared definitions for the machine-mode CSR file: addresses, cause codes,
// operation encodings and bit positions inside mstatus / mie / mip.
package csr_defs;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mcause values
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [4:0]  IRQ_CODE_MSI  = 5'd3;
    localparam logic [4:0]  IRQ_CODE_MTI  = 5'd7;

    // Bit positions (mstatus, mie and mip share the 3/7 layout)
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int IRQ_MSI_BIT      = 3;
    localparam int IRQ_MTI_BIT      = 7;

    // funct3[1:0] operation encoding
    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // mstatus as read by software: MPP hard-wired to machine mode
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v                   = 32'h0000_1800;
        v[MSTATUS_MIE_BIT]  = mie;
        v[MSTATUS_MPIE_BIT] = mpie;
        return v;
    endfunction

    // Two-bit interrupt view (software, timer) placed at its mie/mip positions
    function automatic logic [31:0] irq_pack(input logic msi, input logic mti);
        logic [31:0] v;
        v              = 32'h0;
        v[IRQ_MSI_BIT] = msi;
        v[IRQ_MTI_BIT] = mti;
        return v;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// A write to either half wins over the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    logic [63:0] r_count;

    // Half writes replace their half and hold the other; otherwise count with full carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) r_count[31:0]  <= wdata;
            if (wr_hi) r_count[63:32] <= wdata;
        end else if (inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign q = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file and trap controller for one hart.
// Reads are combinational and return the value before any write this cycle.
// Per-cycle priority: ECALL > interrupt > MRET > CSR write.
import csr_defs::*;

module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_funct3,
    input  logic [31:0] csr_rs1_data,
    input  logic [4:0]  csr_zimm,
    input  logic        csr_we,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [31:0] exc_pc,
    input  logic        int_accept,
    input  logic        instr_retire,
    input  logic        irq_timer,
    input  logic        irq_soft,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic [31:0] trap_vector,
    output logic        mret_taken,
    output logic [31:0] epc_out
);

    // Architectural state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_msie;
    logic        r_mie_mtie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;

    // Operand / write-value path
    csr_op_e     w_op_kind;
    logic [31:0] w_operand;
    logic [31:0] w_wval;
    logic        w_csr_wr;

    // Trap path
    logic        w_msi;
    logic        w_mti;
    logic        w_irq_pend;
    logic [4:0]  w_irq_code;
    logic        w_trap;
    logic        w_mret;
    logic [31:0] w_vec_base;

    // Per-CSR write strobes
    logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause;
    logic w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

    assign w_op_kind = csr_op_e'(csr_funct3[1:0]);
    assign w_operand = csr_funct3[2] ? {27'b0, csr_zimm} : csr_rs1_data;

    // Interrupt qualification; software interrupt outranks timer
    assign w_msi      = r_mie_msie & irq_soft;
    assign w_mti      = r_mie_mtie & irq_timer;
    assign w_irq_pend = r_mstatus_mie & int_accept & (w_msi | w_mti);
    assign w_irq_code = w_msi ? IRQ_CODE_MSI : IRQ_CODE_MTI;

    assign w_trap   = is_ecall | w_irq_pend;
    assign w_mret   = is_mret & ~w_trap;
    // A trap or MRET in the same cycle swallows the CSR write
    assign w_csr_wr = csr_we & (w_op_kind != CSR_OP_NONE) & ~w_trap & ~is_mret;

    assign w_wr_mstatus   = w_csr_wr & (csr_addr == CSR_MSTATUS);
    assign w_wr_mie       = w_csr_wr & (csr_addr == CSR_MIE);
    assign w_wr_mtvec     = w_csr_wr & (csr_addr == CSR_MTVEC);
    assign w_wr_mscratch  = w_csr_wr & (csr_addr == CSR_MSCRATCH);
    assign w_wr_mepc      = w_csr_wr & (csr_addr == CSR_MEPC);
    assign w_wr_mcause    = w_csr_wr & (csr_addr == CSR_MCAUSE);
    assign w_wr_mcycle    = w_csr_wr & (csr_addr == CSR_MCYCLE);
    assign w_wr_mcycleh   = w_csr_wr & (csr_addr == CSR_MCYCLEH);
    assign w_wr_minstret  = w_csr_wr & (csr_addr == CSR_MINSTRET);
    assign w_wr_minstreth = w_csr_wr & (csr_addr == CSR_MINSTRETH);

    // Old-value read mux; unmapped addresses read as zero
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_pack(r_mstatus_mie, r_mstatus_mpie);
            CSR_MIE:       csr_rdata = irq_pack(r_mie_msie, r_mie_mtie);
            CSR_MTVEC:     csr_rdata = r_mtvec;
            CSR_MSCRATCH:  csr_rdata = r_mscratch;
            CSR_MEPC:      csr_rdata = r_mepc;
            CSR_MCAUSE:    csr_rdata = r_mcause;
            CSR_MIP:       csr_rdata = irq_pack(irq_soft, irq_timer);
            CSR_MCYCLE:    csr_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = w_minstret[31:0];
            CSR_MINSTRETH: csr_rdata = w_minstret[63:32];
            CSR_MHARTID:   csr_rdata = HART_ID;
            default:       csr_rdata = 32'h0;
        endcase
    end

    // New value from the read-modify-write op against the old value
    always_comb begin
        w_wval = csr_rdata;
        case (w_op_kind)
            CSR_OP_WRITE: w_wval = w_operand;
            CSR_OP_SET:   w_wval = csr_rdata | w_operand;
            CSR_OP_CLEAR: w_wval = csr_rdata & ~w_operand;
            default:      w_wval = csr_rdata;
        endcase
    end

    // Trap target: vectored mode adds 4*code for interrupts only
    assign w_vec_base  = {r_mtvec[31:2], 2'b00};
    assign trap_vector = (r_mtvec[0] && !is_ecall && w_irq_pend)
                         ? w_vec_base + {25'b0, w_irq_code, 2'b00}
                         : w_vec_base;
    assign trap_taken  = w_trap;
    assign mret_taken  = w_mret;
    assign epc_out     = r_mepc;

    // mstatus interrupt-enable stack: trap pushes, MRET pops, else CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (w_trap) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mstatus_mie  <= w_wval[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= w_wval[MSTATUS_MPIE_BIT];
        end
    end

    // Trap bookkeeping registers; trap capture beats a software write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mepc   <= 32'h0;
            r_mcause <= 32'h0;
        end else if (w_trap) begin
            r_mepc   <= exc_pc & ~32'h3;
            r_mcause <= is_ecall ? CAUSE_ECALL_M : {1'b1, 26'b0, w_irq_code};
        end else begin
            if (w_wr_mepc)   r_mepc   <= w_wval & ~32'h3;
            if (w_wr_mcause) r_mcause <= w_wval;
        end
    end

    // Plain software-owned registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie_msie <= 1'b0;
            r_mie_mtie <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'h0;
        end else begin
            if (w_wr_mie) begin
                r_mie_msie <= w_wval[IRQ_MSI_BIT];
                r_mie_mtie <= w_wval[IRQ_MTI_BIT];
            end
            if (w_wr_mtvec)    r_mtvec    <= w_wval & ~32'h2;
            if (w_wr_mscratch) r_mscratch <= w_wval;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (w_wr_mcycle),
        .wr_hi (w_wr_mcycleh),
        .wdata (w_wval),
        .q     (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instr_retire),
        .wr_lo (w_wr_minstret),
        .wr_hi (w_wr_minstreth),
        .wdata (w_wval),
        .q     (w_minstret)
    );

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: CSR ops, counters, traps, MRET and reset.
module tb_csr_file;

    localparam logic [31:0] TB_HART_ID = 32'd5;
    localparam logic [31:0] TB_MTVEC_R = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [2:0]  csr_funct3;
    logic [31:0] csr_rs1_data;
    logic [4:0]  csr_zimm;
    logic        csr_we;
    logic        is_ecall;
    logic        is_mret;
    logic [31:0] exc_pc;
    logic        int_accept;
    logic        instr_retire;
    logic        irq_timer;
    logic        irq_soft;
    logic [31:0] csr_rdata;
    logic        trap_taken;
    logic [31:0] trap_vector;
    logic        mret_taken;
    logic [31:0] epc_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] old_v;

    csr_file #(.HART_ID(TB_HART_ID), .MTVEC_RESET(TB_MTVEC_R)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_funct3   (csr_funct3),
        .csr_rs1_data (csr_rs1_data),
        .csr_zimm     (csr_zimm),
        .csr_we       (csr_we),
        .is_ecall     (is_ecall),
        .is_mret      (is_mret),
        .exc_pc       (exc_pc),
        .int_accept   (int_accept),
        .instr_retire (instr_retire),
        .irq_timer    (irq_timer),
        .irq_soft     (irq_soft),
        .csr_rdata    (csr_rdata),
        .trap_taken   (trap_taken),
        .trap_vector  (trap_vector),
        .mret_taken   (mret_taken),
        .epc_out      (epc_out)
    );

    // Clock: 20 ns period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one clock; leaves time at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational read of one CSR, no write
    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        csr_addr = a;
        csr_we   = 1'b0;
        #1;
        v = csr_rdata;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check_eq(tag, v, exp);
    endtask

    // One CSR instruction: returns the old value seen during the write cycle
    task automatic csr_op(input logic [11:0] a, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [4:0] zimm,
                          output logic [31:0] old);
        csr_addr     = a;
        csr_funct3   = f3;
        csr_rs1_data = rs1;
        csr_zimm     = zimm;
        csr_we       = 1'b1;
        #1;
        old = csr_rdata;
        tick();
        csr_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        csr_addr = 12'h0; csr_funct3 = 3'b0; csr_rs1_data = 32'h0; csr_zimm = 5'h0;
        csr_we = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; exc_pc = 32'h0;
        int_accept = 1'b0; instr_retire = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset state
        check_eq("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
        check_eq("rst_mret_taken", {31'b0, mret_taken}, 32'h0);
        check_eq("rst_epc_out", epc_out, 32'h0);
        rd_check("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_check("rst_mtvec", 12'h305, TB_MTVEC_R);
        rd_check("rst_mhartid", 12'hF14, TB_HART_ID);
        rd_check("rst_mcycle", 12'hB00, 32'd0);
        tick();
        rd_check("rst_mie", 12'h304, 32'h0);
        rd_check("rst_mscratch", 12'h340, 32'h0);
        repeat (4) tick();
        rd_check("mcycle_5", 12'hB00, 32'd5);

        // 2: read-old RMW on mscratch
        csr_op(12'h340, 3'b001, 32'hDEAD_BEEF, 5'h0, old_v);
        check_eq("rw_old", old_v, 32'h0);
        csr_op(12'h340, 3'b110, 32'h0, 5'h0F, old_v);
        check_eq("rsi_old", old_v, 32'hDEAD_BEEF);
        csr_op(12'h340, 3'b011, 32'h0000_00F0, 5'h0, old_v);
        check_eq("rc_old", old_v, 32'hDEAD_BEEF);
        rd_check("mscratch_final", 12'h340, 32'hDEAD_BE0F);
        csr_op(12'h340, 3'b000, 32'h1234_5678, 5'h0, old_v);
        rd_check("f3_00_no_write", 12'h340, 32'hDEAD_BE0F);
        csr_op(12'h7C0, 3'b001, 32'hFFFF_FFFF, 5'h0, old_v);
        rd_check("unmapped_read", 12'h7C0, 32'h0);
        csr_op(12'hF14, 3'b001, 32'hFFFF_FFFF, 5'h0, old_v);
        rd_check("mhartid_ro", 12'hF14, TB_HART_ID);
        csr_op(12'h305, 3'b001, 32'h0000_0103, 5'h0, old_v);
        rd_check("mtvec_bit1", 12'h305, 32'h0000_0101);
        csr_op(12'h341, 3'b001, 32'h0000_0777, 5'h0, old_v);
        rd_check("mepc_align", 12'h341, 32'h0000_0774);

        // 3: ECALL with a competing MRET and CSR write
        csr_op(12'h305, 3'b001, 32'h0000_0100, 5'h0, old_v);
        csr_op(12'h300, 3'b110, 32'h0, 5'h08, old_v);
        rd_check("mstatus_mie1", 12'h300, 32'h0000_1808);
        exc_pc = 32'h0000_2003; is_ecall = 1'b1; is_mret = 1'b1;
        csr_addr = 12'h340; csr_funct3 = 3'b001; csr_rs1_data = 32'h1111_1111; csr_we = 1'b1;
        #1;
        check_eq("ecall_taken", {31'b0, trap_taken}, 32'h1);
        check_eq("ecall_vector", trap_vector, 32'h0000_0100);
        check_eq("ecall_mret_drop", {31'b0, mret_taken}, 32'h0);
        tick();
        is_ecall = 1'b0; is_mret = 1'b0; csr_we = 1'b0;
        rd_check("ecall_wr_drop", 12'h340, 32'hDEAD_BE0F);
        rd_check("ecall_mepc", 12'h341, 32'h0000_2000);
        rd_check("ecall_mcause", 12'h342, 32'd11);
        rd_check("ecall_mstatus", 12'h300, 32'h0000_1880);

        // 5: MRET back to mepc
        is_mret = 1'b1;
        #1;
        check_eq("mret_taken", {31'b0, mret_taken}, 32'h1);
        check_eq("mret_epc", epc_out, 32'h0000_2000);
        check_eq("mret_no_trap", {31'b0, trap_taken}, 32'h0);
        tick();
        is_mret = 1'b0;
        rd_check("mret_mstatus", 12'h300, 32'h0000_1888);

        // 4: vectored interrupts, MSI beats MTI
        csr_op(12'h305, 3'b001, 32'h0000_0101, 5'h0, old_v);
        csr_op(12'h304, 3'b001, 32'hFFFF_FFFF, 5'h0, old_v);
        rd_check("mie_mask", 12'h304, 32'h0000_0088);
        irq_timer = 1'b1; irq_soft = 1'b1; exc_pc = 32'h0000_3000;
        rd_check("mip_both", 12'h344, 32'h0000_0088);
        check_eq("irq_no_accept", {31'b0, trap_taken}, 32'h0);
        int_accept = 1'b1;
        #1;
        check_eq("irq_taken", {31'b0, trap_taken}, 32'h1);
        check_eq("irq_vector_msi", trap_vector, 32'h0000_010C);
        tick();
        int_accept = 1'b0;
        rd_check("irq_mcause_msi", 12'h342, 32'h8000_0003);
        rd_check("irq_mepc", 12'h341, 32'h0000_3000);
        rd_check("irq_mstatus", 12'h300, 32'h0000_1880);
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0; irq_soft = 1'b0; int_accept = 1'b1;
        #1;
        check_eq("irq_vector_mti", trap_vector, 32'h0000_011C);
        tick();
        int_accept = 1'b0; irq_timer = 1'b0;
        rd_check("irq_mcause_mti", 12'h342, 32'h8000_0007);

        // 6: mcycle carry and dropped write under ECALL
        csr_op(12'hB80, 3'b001, 32'h0, 5'h0, old_v);
        csr_op(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'h0, old_v);
        rd_check("mcycle_lo_ff", 12'hB00, 32'hFFFF_FFFF);
        rd_check("mcycleh_0", 12'hB80, 32'h0);
        tick();
        rd_check("mcycle_wrap", 12'hB00, 32'h0);
        rd_check("mcycleh_carry", 12'hB80, 32'h1);
        exc_pc = 32'h0000_4000; is_ecall = 1'b1;
        csr_addr = 12'hB80; csr_funct3 = 3'b001; csr_rs1_data = 32'hAAAA_AAAA; csr_we = 1'b1;
        #1;
        check_eq("ecall6_taken", {31'b0, trap_taken}, 32'h1);
        tick();
        is_ecall = 1'b0; csr_we = 1'b0;
        rd_check("mcycleh_drop", 12'hB80, 32'h1);
        rd_check("mcycle_counted", 12'hB00, 32'h1);

        // minstret: write suppresses retire increment
        instr_retire = 1'b1;
        csr_op(12'hB02, 3'b001, 32'd5, 5'h0, old_v);
        rd_check("minstret_wr", 12'hB02, 32'd5);
        tick();
        instr_retire = 1'b0;
        rd_check("minstret_inc", 12'hB02, 32'd6);
        tick();
        rd_check("minstret_hold", 12'hB02, 32'd6);
        rd_check("minstreth", 12'hB82, 32'd0);

        // Reset mid-trap clears everything at once
        exc_pc = 32'h0000_5000; is_ecall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_epc", epc_out, 32'h0);
        is_ecall = 1'b0;
        rd_check("arst_mcause", 12'h342, 32'h0);
        rd_check("arst_mstatus", 12'h300, 32'h0000_1800);
        rd_check("arst_mtvec", 12'h305, TB_MTVEC_R);
        tick();
        rst_n = 1'b1;
        rd_check("arst_mscratch", 12'h340, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
